// File: rtl/crossing_pkg.sv
// ============================================================================
// Module : crossing_pkg
// Brief  : Shared types, state encodings and limit helpers for the
//          river-crossing game engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package crossing_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_CROSS = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    localparam logic [1:0] GS_LOSE = 2'd0;
    localparam logic [1:0] GS_WIN  = 2'd1;
    localparam logic [1:0] GS_PLAY = 2'd2;
    localparam logic [1:0] GS_IDLE = 2'd3;

    // Cat eats mouse (bit 0*3+2) and dog eats cat (bit 1*3+0).
    localparam logic [8:0] DEFAULT_EAT_MASK = 9'h00C;

    function automatic int move_limit(input logic [1:0] diff, input int lim1, input int lim2);
        if (diff == 2'd0)
            return 0;
        else if (diff == 2'd1)
            return lim1;
        else
            return lim2;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            S_IDLE:  return GS_IDLE;
            S_WIN:   return GS_WIN;
            S_LOSE:  return GS_LOSE;
            default: return GS_PLAY;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_countdown.sv
// ============================================================================
// Module : bcd_countdown
// Brief  : Two-digit BCD down-counter with load, tick enable and zero flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_countdown (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_tens,
    input  logic [3:0] i_load_ones,
    input  logic       i_tick,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_zero
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (i_load) begin
            r_tens <= i_load_tens;
            r_ones <= i_load_ones;
        end else if (i_tick && !o_zero) begin
            if (r_ones == 4'd0) begin
                r_ones <= 4'd9;
                r_tens <= r_tens - 4'd1;
            end else begin
                r_ones <= r_ones - 4'd1;
            end
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;
    assign o_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

endmodule

`default_nettype wire

// File: rtl/crossing_game_core.sv
// ============================================================================
// Module : crossing_game_core
// Brief  : Parametrised river-crossing puzzle engine. Optional countdown
//          timer enabled by defining TIMER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module crossing_game_core
    import crossing_pkg::*;
#(
    parameter int                         N_ITEMS      = 3,
    parameter int                         CAP          = 1,
    parameter logic [N_ITEMS*N_ITEMS-1:0] EAT_MASK     = DEFAULT_EAT_MASK,
    parameter int                         CROSS_TICKS  = 4,
    parameter int                         MOVE_W       = 6,
    parameter int                         MOVE_LIMIT_1 = 11,
    parameter int                         MOVE_LIMIT_2 = 7,
    parameter int                         TIME_LIMIT_0 = 99,
    parameter int                         TIME_LIMIT_1 = 60,
    parameter int                         TIME_LIMIT_2 = 30
) (
    input  logic               clk_1kHz,
    input  logic               btn_0,
    input  logic               tick_1hz,
    input  logic               tick_4hz,
    input  logic [N_ITEMS-1:0] item_btn,
    input  logic               canoe_btn,
    input  logic               start_sw,
    input  logic [1:0]         difficulty,
    output logic [N_ITEMS-1:0] item_pos,
    output logic [N_ITEMS-1:0] item_aboard,
    output logic               canoe_pos,
    output logic               canoe_moving,
    output logic [MOVE_W-1:0]  move_cnt,
    output logic [3:0]         time_tens,
    output logic [3:0]         time_ones,
    output logic [1:0]         game_state
);

    localparam int TICK_W = $clog2(CROSS_TICKS + 1);
    localparam int SEL_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    state_t              r_state,    w_nxt_state;
    logic [N_ITEMS-1:0]  r_item_pos, w_nxt_pos;
    logic [N_ITEMS-1:0]  r_aboard,   w_nxt_aboard;
    logic                r_canoe_pos, w_nxt_canoe_pos;
    logic [MOVE_W-1:0]   r_move_cnt, w_nxt_move_cnt;
    logic [TICK_W-1:0]   r_tick_cnt, w_nxt_tick_cnt;
    logic [1:0]          r_diff,     w_nxt_diff;
    logic [N_ITEMS-1:0]  r_item_prev;
    logic                r_canoe_prev;

    logic [N_ITEMS-1:0]  w_item_edge;
    logic                w_canoe_edge;
    logic [N_ITEMS-1:0]  w_bank;
    logic [N_ITEMS-1:0]  w_arr_pos;
    logic                w_arr_win;
    logic                w_conflict;
    logic                w_found;
    logic [SEL_W-1:0]    w_sel;
    logic                w_last_tick;
    logic [MOVE_W-1:0]   w_limit;
    logic                w_time_out;

    assign w_item_edge  = item_btn & ~r_item_prev;
    assign w_canoe_edge = canoe_btn & ~r_canoe_prev;
    // Items left behind on the departure bank.
    assign w_bank       = ~r_aboard & ~(r_item_pos ^ {N_ITEMS{r_canoe_pos}});
    assign w_arr_pos    = r_item_pos ^ r_aboard;
    assign w_arr_win    = (&w_arr_pos) && !r_canoe_pos;
    assign w_last_tick  = tick_4hz && (r_tick_cnt == TICK_W'(CROSS_TICKS - 1));
    assign w_limit      = MOVE_W'(move_limit(r_diff, MOVE_LIMIT_1, MOVE_LIMIT_2));

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (w_item_edge[k] && !w_found) begin
                w_found = 1'b1;
                w_sel   = SEL_W'(k);
            end
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < N_ITEMS; i++)
            for (int j = 0; j < N_ITEMS; j++)
                if (EAT_MASK[i*N_ITEMS+j] && w_bank[i] && w_bank[j])
                    w_conflict = 1'b1;
    end

`ifdef TIMER_EN
    logic [7:0] w_load_bcd;
    logic       w_tmr_load;
    logic       w_tmr_tick;
    logic       w_tmr_zero;
    logic       w_active;

    always_comb begin
        case (difficulty)
            2'd0:    w_load_bcd = to_bcd(TIME_LIMIT_0);
            2'd1:    w_load_bcd = to_bcd(TIME_LIMIT_1);
            default: w_load_bcd = to_bcd(TIME_LIMIT_2);
        endcase
    end

    assign w_active   = (r_state == S_PLAY) || (r_state == S_CROSS);
    // Switch off clears the digits; a start from IDLE loads the limit.
    assign w_tmr_load = !start_sw || (r_state == S_IDLE);
    assign w_tmr_tick = tick_1hz && w_active;

    bcd_countdown u_timer (
        .clk         (clk_1kHz),
        .rst         (btn_0),
        .i_load      (w_tmr_load),
        .i_load_tens (start_sw ? w_load_bcd[7:4] : 4'd0),
        .i_load_ones (start_sw ? w_load_bcd[3:0] : 4'd0),
        .i_tick      (w_tmr_tick),
        .o_tens      (time_tens),
        .o_ones      (time_ones),
        .o_zero      (w_tmr_zero)
    );

    assign w_time_out = w_tmr_zero && w_active;
`else
    logic w_unused;
    assign w_unused   = tick_1hz;
    assign time_tens  = 4'd0;
    assign time_ones  = 4'd0;
    assign w_time_out = 1'b0;
`endif

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_pos       = r_item_pos;
        w_nxt_aboard    = r_aboard;
        w_nxt_canoe_pos = r_canoe_pos;
        w_nxt_move_cnt  = r_move_cnt;
        w_nxt_tick_cnt  = r_tick_cnt;
        w_nxt_diff      = r_diff;
        if (!start_sw) begin
            w_nxt_state     = S_IDLE;
            w_nxt_pos       = '0;
            w_nxt_aboard    = '0;
            w_nxt_canoe_pos = 1'b0;
            w_nxt_move_cnt  = '0;
            w_nxt_tick_cnt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nxt_state     = S_PLAY;
                    w_nxt_diff      = difficulty;
                    w_nxt_pos       = '0;
                    w_nxt_aboard    = '0;
                    w_nxt_canoe_pos = 1'b0;
                    w_nxt_move_cnt  = '0;
                    w_nxt_tick_cnt  = '0;
                end
                S_PLAY: begin
                    if (w_time_out) begin
                        w_nxt_state = S_LOSE;
                    end else if (w_found) begin
                        if (r_item_pos[w_sel] == r_canoe_pos) begin
                            if (r_aboard[w_sel])
                                w_nxt_aboard[w_sel] = 1'b0;
                            else if ($countones(r_aboard) < CAP)
                                w_nxt_aboard[w_sel] = 1'b1;
                        end
                    end else if (w_canoe_edge) begin
                        if (w_conflict) begin
                            w_nxt_state = S_LOSE;
                        end else begin
                            if (r_move_cnt != '1)
                                w_nxt_move_cnt = r_move_cnt + 1'b1;
                            w_nxt_tick_cnt = '0;
                            w_nxt_state    = S_CROSS;
                        end
                    end
                end
                S_CROSS: begin
                    if (w_last_tick) begin
                        w_nxt_pos       = w_arr_pos;
                        w_nxt_canoe_pos = ~r_canoe_pos;
                        w_nxt_aboard    = '0;
                        if (w_arr_win)
                            w_nxt_state = S_WIN;
                        else if ((r_diff != 2'd0) && (r_move_cnt >= w_limit))
                            w_nxt_state = S_LOSE;
                        else if (w_time_out)
                            w_nxt_state = S_LOSE;
                        else
                            w_nxt_state = S_PLAY;
                    end else if (w_time_out) begin
                        w_nxt_state = S_LOSE;
                    end else if (tick_4hz) begin
                        w_nxt_tick_cnt = r_tick_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_1kHz) begin
        r_item_prev  <= item_btn;
        r_canoe_prev <= canoe_btn;
        if (btn_0) begin
            r_state     <= S_IDLE;
            r_item_pos  <= '0;
            r_aboard    <= '0;
            r_canoe_pos <= 1'b0;
            r_move_cnt  <= '0;
            r_tick_cnt  <= '0;
            r_diff      <= 2'd0;
        end else begin
            r_state     <= w_nxt_state;
            r_item_pos  <= w_nxt_pos;
            r_aboard    <= w_nxt_aboard;
            r_canoe_pos <= w_nxt_canoe_pos;
            r_move_cnt  <= w_nxt_move_cnt;
            r_tick_cnt  <= w_nxt_tick_cnt;
            r_diff      <= w_nxt_diff;
        end
    end

    assign item_pos     = r_item_pos;
    assign item_aboard  = r_aboard;
    assign canoe_pos    = r_canoe_pos;
    assign canoe_moving = (r_state == S_CROSS);
    assign move_cnt     = r_move_cnt;
    assign game_state   = state_code(r_state);

endmodule

`default_nettype wire

// File: tb/tb_crossing_game_core.sv
// ============================================================================
// Module : tb_crossing_game_core
// Brief  : Scoreboard bench for crossing_game_core (default parameters;
//          countdown scenario included when TIMER_EN is defined).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crossing_game_core;

    logic       clk = 1'b0;
    logic       btn_0 = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_4hz = 1'b0;
    logic [2:0] item_btn = 3'b000;
    logic       canoe_btn = 1'b0;
    logic       start_sw = 1'b0;
    logic [1:0] difficulty = 2'd0;
    logic [2:0] item_pos;
    logic [2:0] item_aboard;
    logic       canoe_pos;
    logic       canoe_moving;
    logic [5:0] move_cnt;
    logic [3:0] time_tens;
    logic [3:0] time_ones;
    logic [1:0] game_state;

    always #5 clk = ~clk;

    crossing_game_core dut (
        .clk_1kHz     (clk),
        .btn_0        (btn_0),
        .tick_1hz     (tick_1hz),
        .tick_4hz     (tick_4hz),
        .item_btn     (item_btn),
        .canoe_btn    (canoe_btn),
        .start_sw     (start_sw),
        .difficulty   (difficulty),
        .item_pos     (item_pos),
        .item_aboard  (item_aboard),
        .canoe_pos    (canoe_pos),
        .canoe_moving (canoe_moving),
        .move_cnt     (move_cnt),
        .time_tens    (time_tens),
        .time_ones    (time_ones),
        .game_state   (game_state)
    );

    typedef struct {
        string      name;
        logic [1:0] gs;
        logic [2:0] pos;
        logic [2:0] ab;
        logic       cp;
        logic       mv;
        logic [5:0] mc;
        logic [7:0] t;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: compares every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (game_state !== e.gs || item_pos !== e.pos || item_aboard !== e.ab ||
                    canoe_pos !== e.cp || canoe_moving !== e.mv || move_cnt !== e.mc ||
                    {time_tens, time_ones} !== e.t) begin
                    failures++;
                    $display("FAIL %s: got gs=%0d pos=%b ab=%b cp=%b mv=%b mc=%0d t=%h%h ; want gs=%0d pos=%b ab=%b cp=%b mv=%b mc=%0d t=%h",
                             e.name, game_state, item_pos, item_aboard, canoe_pos, canoe_moving,
                             move_cnt, time_tens, time_ones, e.gs, e.pos, e.ab, e.cp, e.mv, e.mc, e.t);
                end
            end
        end
    end

    function automatic logic [7:0] tl(input int d);
`ifdef TIMER_EN
        case (d)
            0:       return 8'h99;
            1:       return 8'h60;
            default: return 8'h30;
        endcase
`else
        return (d < 0) ? 8'h01 : 8'h00;
`endif
    endfunction

    task automatic chk(input string n, input logic [1:0] gs, input logic [2:0] pos,
                       input logic [2:0] ab, input logic cp, input logic mv,
                       input logic [5:0] mc, input logic [7:0] t);
        exp_t e;
        e.name = n; e.gs = gs; e.pos = pos; e.ab = ab;
        e.cp = cp; e.mv = mv; e.mc = mc; e.t = t;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_item(input int k);
        item_btn[k] = 1'b1;
        cyc();
        item_btn[k] = 1'b0;
        cyc();
    endtask

    task automatic press_canoe();
        canoe_btn = 1'b1;
        cyc();
        canoe_btn = 1'b0;
        cyc();
    endtask

    task automatic pulse_4hz(input int n);
        for (int i = 0; i < n; i++) begin
            tick_4hz = 1'b1;
            cyc();
            tick_4hz = 1'b0;
            cyc();
        end
    endtask

    task automatic pulse_1hz(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            cyc();
            tick_1hz = 1'b0;
            cyc();
        end
    endtask

    task automatic restart(input int d);
        start_sw = 1'b0;
        cyc();
        chk("idle_clear", 2'd3, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h00);
        start_sw   = 1'b1;
        difficulty = 2'(d);
        cyc();
    endtask

    initial begin
        int         ks[7];
        logic [2:0] ps[7];
        ks = '{0, -1, 1, 0, 2, -1, 0};
        ps = '{3'b001, 3'b001, 3'b011, 3'b010, 3'b110, 3'b110, 3'b111};

        // Reset state
        cyc();
        cyc();
        chk("reset", 2'd3, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h00);
        btn_0 = 1'b0;

        // Full solution at difficulty 2
        start_sw   = 1'b1;
        difficulty = 2'd2;
        cyc();
        chk("start", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, tl(2));
        for (int s = 0; s < 7; s++) begin
            if (ks[s] >= 0)
                press_item(ks[s]);
            press_canoe();
            if (s == 0)
                chk("depart1", 2'd2, 3'b000, 3'b001, 1'b0, 1'b1, 6'd1, tl(2));
            pulse_4hz(4);
            chk($sformatf("solve_%0d", s), (s == 6) ? 2'd1 : 2'd2, ps[s], 3'b000,
                1'(s % 2 == 0), 1'b0, 6'(s + 1), tl(2));
        end
        press_canoe();
        chk("win_frozen", 2'd1, 3'b111, 3'b000, 1'b1, 1'b0, 6'd7, tl(2));

        // Empty canoe leaves all three together
        restart(2);
        press_canoe();
        chk("eat_lose", 2'd0, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, tl(2));

        // Capacity 1
        restart(0);
        press_item(0);
        chk("cap_cat", 2'd2, 3'b000, 3'b001, 1'b0, 1'b0, 6'd0, tl(0));
        press_item(1);
        chk("cap_dog_block", 2'd2, 3'b000, 3'b001, 1'b0, 1'b0, 6'd0, tl(0));
        press_item(0);
        chk("cap_cat_off", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, tl(0));

        // Move limit at difficulty 2 by shuttling the cat
        restart(2);
        for (int n = 1; n <= 7; n++) begin
            press_item(0);
            press_canoe();
            if (n == 1) begin
                pulse_4hz(3);
                chk("mid_cross", 2'd2, 3'b000, 3'b001, 1'b0, 1'b1, 6'd1, tl(2));
                pulse_4hz(1);
                press_item(1);
                chk("far_bank_ignored", 2'd2, 3'b001, 3'b000, 1'b1, 1'b0, 6'd1, tl(2));
            end else begin
                pulse_4hz(4);
            end
            if (n >= 6)
                chk($sformatf("shuttle_%0d", n), (n == 7) ? 2'd0 : 2'd2,
                    (n % 2 == 1) ? 3'b001 : 3'b000, 3'b000, 1'(n % 2), 1'b0, 6'(n), tl(2));
        end

        // Held key fires once; simultaneous edges; item beats canoe
        restart(0);
        item_btn[2] = 1'b1;
        repeat (50) cyc();
        item_btn[2] = 1'b0;
        cyc();
        chk("held_once", 2'd2, 3'b000, 3'b100, 1'b0, 1'b0, 6'd0, tl(0));
        press_item(2);
        item_btn = 3'b011;
        cyc();
        item_btn = 3'b000;
        cyc();
        chk("lowest_wins", 2'd2, 3'b000, 3'b001, 1'b0, 1'b0, 6'd0, tl(0));
        item_btn[0] = 1'b1;
        canoe_btn   = 1'b1;
        cyc();
        item_btn  = 3'b000;
        canoe_btn = 1'b0;
        cyc();
        chk("canoe_dropped", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, tl(0));

        // Reset in the middle of a crossing
        press_item(0);
        press_canoe();
        pulse_4hz(2);
        btn_0 = 1'b1;
        cyc();
        chk("reset_mid_cross", 2'd3, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h00);
        btn_0 = 1'b0;

`ifdef TIMER_EN
        restart(1);
        chk("timer_load", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h60);
        pulse_1hz(1);
        chk("timer_borrow60", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h59);
        pulse_1hz(49);
        chk("timer_10", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h10);
        pulse_1hz(1);
        chk("timer_09", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h09);
        pulse_1hz(8);
        chk("timer_01", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h01);
        pulse_1hz(1);
        chk("timer_expire", 2'd0, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h00);
        pulse_1hz(1);
        chk("timer_hold", 2'd0, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, 8'h00);
`else
        restart(1);
        pulse_1hz(3);
        chk("timer_off", 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0, tl(1));
`endif

        cyc();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crossing_game_core.md
Name: crossing_game_core

Overview:
Parametrised game engine for the river-crossing puzzle. Generalises the fixed cat/dog/mouse/canoe logic to N_ITEMS passengers, a configurable canoe capacity, a predator/prey conflict mask, a crossing animation delay and difficulty-selected move and time limits. It sits between the debounce/divider blocks and the matrix/segment scanning block, and supplies it with positions, counters and game state.

Parameters:
N_ITEMS, 3, passenger count (0=cat, 1=dog, 2=mouse by default)
CAP, 1, maximum passengers aboard the canoe
EAT_MASK, 9'h00C, N_ITEMS*N_ITEMS bits; bit i*N_ITEMS+j set means "i eats j when left unattended"
CROSS_TICKS, 4, tick_4hz pulses per crossing
MOVE_W, 6, move counter width
MOVE_LIMIT_1, 11, move limit at difficulty 1
MOVE_LIMIT_2, 7, move limit at difficulty 2
TIME_LIMIT_0 / _1 / _2, 99 / 60 / 30, countdown seconds per difficulty (0..99)

Ports:
clk_1kHz  in  1  system clock
btn_0  in  1  synchronous active-high reset (debounced reset key)
tick_1hz  in  1  single-cycle enable, 1 Hz
tick_4hz  in  1  single-cycle enable, 4 Hz
item_btn  in  N_ITEMS  debounced item keys, level
canoe_btn  in  1  debounced row key, level
start_sw  in  1  run switch
difficulty  in  2  0 easy, 1 medium, 2 hard, 3 treated as 2
item_pos  out  N_ITEMS  0 near bank, 1 far bank
item_aboard  out  N_ITEMS  1 = seated in canoe
canoe_pos  out  1  bank the canoe is at or departing from
canoe_moving  out  1  crossing in progress
move_cnt  out  MOVE_W  departures made, saturating
time_tens, time_ones  out  4 each  BCD remaining time
game_state  out  2  0 lose, 1 win, 2 playing, 3 idle

Behaviour:
- Reset (btn_0 high at a clk edge): state IDLE; item_pos, item_aboard, canoe_pos, canoe_moving, move_cnt all 0; time digits 0/0; game_state 3. Reset overrides everything, including mid-crossing.
- Keys act on the rising edge only, using internal previous-value registers; a held key fires once.
- States: IDLE, PLAY, CROSS, WIN, LOSE.
- IDLE: start_sw=1 latches difficulty, loads the time limit as BCD, and clears positions and move_cnt. Next state PLAY.
- start_sw=0 in any state returns to IDLE next cycle, with the same clears as reset.
- PLAY, item edge k:
  - If item_pos[k]==canoe_pos, toggle item_aboard[k].
  - Boarding is ignored when popcount(item_aboard)==CAP.
  - The edge is ignored when the item is on the other bank.
  - Simultaneous item edges: lowest index wins; the others are dropped.
- PLAY, canoe edge (empty canoe allowed). Evaluate the departure bank: the items with pos==canoe_pos and not aboard.
  - If any pair i,j on that bank has EAT_MASK set, next state is LOSE.
  - Otherwise move_cnt+1 (saturating) and next state CROSS with canoe_moving=1.
  - A canoe edge in the same cycle as an item edge: the item edge is processed and the canoe edge is dropped.
- CROSS: count tick_4hz to CROSS_TICKS. On the final tick:
  - canoe_pos flips and aboard items' pos flips.
  - item_aboard clears, canoe_moving=0.
  - Key edges during CROSS are ignored.
- Arrival checks, same cycle, in priority order:
  1. All item_pos==1 and canoe_pos==1 → WIN.
  2. Otherwise, if difficulty≠0 and move_cnt≥limit → LOSE.
  3. Otherwise → PLAY.
- WIN/LOSE: outputs frozen until start_sw falls or reset.
- game_state reflects the registered state, with 1-cycle latency after the deciding edge.

Optional Feature:
TIMER_EN defined:
- BCD countdown, decremented on tick_1hz in PLAY/CROSS; 10 → 09 borrow handled correctly.
- Reaching 00 forces LOSE.
- If a win and the expiry fall in the same cycle, win takes priority.
- Countdown holds in WIN/LOSE.

TIMER_EN undefined:
- time_tens and time_ones are constant 0.
- Time never causes a loss.

Decomposition:
- Package crossing_pkg: state enum, game_state encodings (LOSE=0, WIN=1, PLAY=2, IDLE=3), default EAT_MASK, difficulty-to-limit function.
- One sub-module bcd_countdown: load value, tick enable, 2-digit decrement, zero flag. Instantiated only under TIMER_EN.

Test Plan:
1. Defaults, start_sw=1, difficulty=2, solve cat→, return, dog→, cat←, mouse→, return, cat→ (CROSS_TICKS=4 each) → game_state=1, move_cnt=7, all item_pos=3'b111.
2. From start, canoe edge with nothing aboard → cat/dog/mouse left together, LOSE immediately (game_state=0, move_cnt=0, canoe_pos=0).
3. CAP=1: press cat then dog → only cat aboard (item_aboard=3'b001); press cat again → 3'b000.
4. difficulty=2: 7 safe non-winning crossings (cat shuttled) → LOSE on 7th arrival, move_cnt=7.
5. TIMER_EN, difficulty=1: 60 tick_1hz pulses without winning → digits step 6/0, 5/9 … 0/0, then LOSE. Assert btn_0 mid-CROSS → every output returns to its reset value next cycle.
6. Hold item_btn[2] high for 50 cycles → exactly one toggle. Edges on item_btn[0] and item_btn[1] in the same cycle → only item 0 boards.
